// File: rtl/dsram_axi_adapter_pkg.sv
// dsram_axi_adapter_pkg: FSM encoding and AXI constants shared by
// the data-SRAM to AXI4 adapter.
package dsram_axi_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  localparam int TIMEOUT_CYC = 255;

endpackage

// File: rtl/dsram_axi_adapter.sv
// dsram_axi_adapter: SRAM-like data port to single-beat AXI4 master.
// Define DSRAM_TIMEOUT_EN to abort responses that never arrive.
module dsram_axi_adapter
  import dsram_axi_adapter_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        rready_q, rready_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        accept;
  logic        tmo;
  logic        unused_rlast;

  // Single-beat bursts: last is implied by the response itself.
  assign unused_rlast = rlast;

  assign accept = data_req & (state_q == IDLE) & ~rst;

`ifdef DSRAM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       waiting;

  assign waiting = (state_q == RD_D) | (state_q == WR_B);
  assign cnt_d   = waiting ? cnt_q + 8'd1 : 8'd0;
  assign tmo     = waiting & (cnt_q == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rready_d  = rready_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ok_d      = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = data_addr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          wdata_d = data_wdata;
          if (data_wr) begin
            state_d   = WR_AW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end
      RD_A: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          rdata_d  = rdata;
          ok_d     = 1'b1;
          err_d    = err_q | (rresp != RESP_OKAY);
          rready_d = 1'b0;
          state_d  = IDLE;
        end else if (tmo) begin
          rdata_d  = DEAD_BEEF;
          ok_d     = 1'b1;
          err_d    = 1'b1;
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_AW: begin
        // Address and data channels retire independently.
        aw_done_d = aw_done_q | (awvalid_q & awready);
        w_done_d  = w_done_q | (wvalid_q & wready);
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (aw_done_d & w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (bvalid || tmo) begin
          ok_d     = 1'b1;
          err_d    = err_q | tmo | (bresp != RESP_OKAY);
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rready_q  <= rready_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign data_addr_ok = accept;
  assign data_data_ok = ok_q;
  assign data_rdata   = rdata_q;
  assign err          = err_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign awvalid = awvalid_q;

  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = bready_q;

endmodule
